xbox_xlr_mem_bank: RTL and testbench
====================================

// Module: xbox_xlr_mem_bank
// PURPOSE
//  Responder end of the XBOX accelerator memory interface: NUM_MEMS line-wide SRAM banks serving the xlr_mem_* master port.
//  Per bank: 256-bit lines (8x32b words), byte-enable writes, fixed 1-cycle registered read latency.
//  A secondary host word port (32b) preloads operands and reads back results.
//  The accelerator port has strict priority; the host port stalls on bank conflict.
// PARAMETERS
//  NUM_MEMS            2  number of banks
//  LOG2_LINES_PER_MEM  8  address bits per bank (2^N lines)
// PORTS
//  clk              in   1                   clock
//  rst_n            in   1                   asynchronous reset, active-low
//  xlr_mem_addr     in   [NUM_MEMS][LOG2]    line address per bank
//  xlr_mem_wdata    in   [NUM_MEMS][8][32]   write line per bank
//  xlr_mem_be       in   [NUM_MEMS][32]      byte enable; bit b covers line byte b (word b/4, byte b%4)
//  xlr_mem_rd       in   [NUM_MEMS]          read strobe
//  xlr_mem_wr       in   [NUM_MEMS]          write strobe
//  xlr_mem_rdata    out  [NUM_MEMS][8][32]   read line, valid the cycle after rd
//  host_req         in   1                   host word access request
//  host_wr          in   1                   1=write, 0=read
//  host_sel         in   clog2(NUM_MEMS)     target bank
//  host_addr        in   LOG2                line address
//  host_word        in   3                   word within line
//  host_wdata       in   32                  write word
//  host_gnt         out  1                   comb: request accepted this cycle
//  host_rdata       out  32                  read word
//  host_rvalid      out  1                   pulse, 1 cycle after granted read
//  conflict_cnt     out  16                  saturating count of host stalls
// BEHAVIOUR
//  Reset: xlr_mem_rdata='0, host_rdata=0, host_rvalid=0, conflict_cnt=0. Array contents are NOT reset.
//  XLR write: on posedge with wr[m]=1, bytes with be[m][b]=1 take wdata; other bytes are unchanged.
//    be=0 with wr=1 is a legal no-op.
//  XLR read: rd[m]=1 at edge N -> xlr_mem_rdata[m] = line at addr, driven from edge N+1.
//    The value holds until the next rd[m]; no rd means no change.
//  rd and wr on the same bank, same cycle: write is performed; rdata returns the pre-write line (read-before-write).
//  Host grant: host_gnt = host_req & ~(xlr_mem_rd[host_sel] | xlr_mem_wr[host_sel]).
//    Ungranted requests must be held by the host.
//    Each ungranted cycle increments conflict_cnt, saturating at 16'hFFFF.
//  Host write (granted): 4 bytes of word host_word are written; the rest of the line is unchanged.
//  Host read (granted): host_rdata/host_rvalid are valid at the next edge; host_rvalid is 1 for exactly 1 cycle.
//  Host on bank A and XLR on bank B (A!=B), same cycle: both proceed.
//  Per-bank pipeline: 1-bit rd_pend register feeds the output mux. No FSM beyond it; all ports are fully pipelined at 1 op/cycle.
//  Reset mid-operation: pending reads are dropped (rvalid=0, rdata=0); already-written lines keep their contents.
//  host_sel >= NUM_MEMS: gnt=1, write ignored, read returns 32'h0 with rvalid=1.
// STRUCTURE
//  Package xbox_mem_pkg holds:
//    LINE_WORDS=8, WORD_W=32, LINE_BYTES=32
//    typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t
//    typedef logic [LINE_BYTES-1:0] be_t
//  Sub-module xbox_mem_line_sram: one bank, single write port, byte enables, registered read.
//    Instantiated NUM_MEMS times via generate.
//  Top level: host/XLR muxing onto each bank port, word-to-byte-enable expansion, grant logic, conflict counter.
// TESTING
//  1. Host write words 0..7 of bank0 line0 with 1,2,3,4,5,6,7,8, then xlr rd[0] addr 0
//     -> next cycle rdata[0] = {8,7,6,5,4,3,2,1}.
//  2. xlr wr[0] addr 1, wdata all 32'hFFFFFFFF, be=32'h0000000F, prior line 0; then rd
//     -> word0=FFFFFFFF, words1..7=0.
//  3. Same cycle rd+wr[0] addr 2, old line = all 32'hA5A5A5A5, new = all 32'h0
//     -> rdata = A5 line; a following rd returns 0.
//  4. host_req read bank0 while xlr_mem_rd[0]=1 for 3 cycles -> gnt=0 for 3 cycles, conflict_cnt=3, then gnt=1;
//     the same request on bank1 is granted immediately.
//  5. Assert rst_n=0 the cycle after a granted host read -> host_rvalid stays 0, outputs 0;
//     after reset, readback of previously written line 0 still returns {8..1}.
//  6. Back-to-back xlr reads addr 0,1,2 on consecutive cycles -> rdata shows lines 0,1,2 on the 3 following cycles.

Source files
------------

// File: rtl/xbox_mem_pkg.sv
// Shared line/byte-enable types and helpers for the XBOX accelerator memory banks.
// A line is 8 x 32-bit words; byte b of a line lives in word b/4, byte lane b%4.
package xbox_mem_pkg;

    localparam int LINE_WORDS = 8;
    localparam int WORD_W     = 32;
    localparam int LINE_BYTES = 32;

    typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;
    typedef logic [LINE_BYTES-1:0]              be_t;

    // Byte enables covering the four bytes of one word within a line.
    function automatic be_t word_be(input logic [2:0] word);
        be_t be;
        be = '0;
        be[word*4 +: 4] = 4'hF;
        return be;
    endfunction

    function automatic line_t word_splat(input logic [WORD_W-1:0] w);
        line_t l;
        for (int i = 0; i < LINE_WORDS; i++) begin
            l[i] = w;
        end
        return l;
    endfunction

endpackage

// File: rtl/xbox_mem_line_sram.sv
// One line-wide SRAM bank: single port, byte-enable writes, registered read.
// A read and write to the same address in one cycle returns the pre-write line.
module xbox_mem_line_sram
    import xbox_mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  line_t             wdata,
    input  be_t               be,
    output line_t             rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [LINE_BYTES-1:0][7:0] mem [DEPTH];
    logic [LINE_BYTES-1:0][7:0] wbytes;

    assign wbytes = wdata;

    // Storage is deliberately not reset so it maps onto plain SRAM macros.
    always_ff @(posedge clk) begin
        if (wr) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (be[b]) begin
                    mem[addr][b] <= wbytes[b];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/xbox_xlr_mem_bank.sv
// Responder for the XBOX accelerator memory port: NUM_MEMS line banks shared with a
// host word port. The accelerator always wins a bank; the host stalls and is counted.
module xbox_xlr_mem_bank
    import xbox_mem_pkg::*;
#(
    parameter int NUM_MEMS           = 2,
    parameter int LOG2_LINES_PER_MEM = 8,
    localparam int SEL_W             = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]  xlr_mem_addr,
    input  line_t [NUM_MEMS-1:0]                         xlr_mem_wdata,
    input  be_t   [NUM_MEMS-1:0]                         xlr_mem_be,
    input  logic [NUM_MEMS-1:0]                          xlr_mem_rd,
    input  logic [NUM_MEMS-1:0]                          xlr_mem_wr,
    output line_t [NUM_MEMS-1:0]                         xlr_mem_rdata,
    input  logic                                         host_req,
    input  logic                                         host_wr,
    input  logic [SEL_W-1:0]                             host_sel,
    input  logic [LOG2_LINES_PER_MEM-1:0]                host_addr,
    input  logic [2:0]                                   host_word,
    input  logic [WORD_W-1:0]                            host_wdata,
    output logic                                         host_gnt,
    output logic [WORD_W-1:0]                            host_rdata,
    output logic                                         host_rvalid,
    output logic [15:0]                                  conflict_cnt
);

    logic                           host_sel_ok;
    logic                           host_bank_busy;
    line_t                          host_line;
    be_t                            host_be;

    logic [NUM_MEMS-1:0]            bank_rd;
    logic [NUM_MEMS-1:0]            bank_wr;
    logic [LOG2_LINES_PER_MEM-1:0]  bank_addr  [NUM_MEMS];
    line_t                          bank_wdata [NUM_MEMS];
    be_t                            bank_be    [NUM_MEMS];
    line_t                          bank_rdata [NUM_MEMS];

    logic [NUM_MEMS-1:0]            xlr_pend;
    line_t                          xlr_hold   [NUM_MEMS];
    logic                           host_pend;
    logic                           host_pend_ok;
    logic [SEL_W-1:0]               host_sel_q;
    logic [2:0]                     host_word_q;
    logic [WORD_W-1:0]              host_hold;

    // An out-of-range host_sel matches no bank: it is never busy, so it is granted and ignored.
    always_comb begin
        host_sel_ok    = 1'b0;
        host_bank_busy = 1'b0;
        for (int m = 0; m < NUM_MEMS; m++) begin
            if (host_sel == SEL_W'(m)) begin
                host_sel_ok    = 1'b1;
                host_bank_busy = xlr_mem_rd[m] | xlr_mem_wr[m];
            end
        end
    end

    assign host_gnt  = host_req & ~host_bank_busy;
    assign host_line = word_splat(host_wdata);
    assign host_be   = word_be(host_word);

    always_comb begin
        bank_rd = '0;
        bank_wr = '0;
        for (int m = 0; m < NUM_MEMS; m++) begin
            bank_addr[m]  = (xlr_mem_rd[m] | xlr_mem_wr[m]) ? xlr_mem_addr[m] : host_addr;
            bank_wdata[m] = xlr_mem_wr[m] ? xlr_mem_wdata[m] : host_line;
            bank_be[m]    = xlr_mem_wr[m] ? xlr_mem_be[m] : host_be;
            bank_rd[m]    = xlr_mem_rd[m];
            bank_wr[m]    = xlr_mem_wr[m];
            if (host_gnt && host_sel == SEL_W'(m)) begin
                bank_rd[m] = ~host_wr;
                bank_wr[m] = host_wr;
            end
        end
    end

    for (genvar m = 0; m < NUM_MEMS; m++) begin : g_bank
        xbox_mem_line_sram #(
            .ADDR_W (LOG2_LINES_PER_MEM)
        ) u_sram (
            .clk   (clk),
            .rst_n (rst_n),
            .rd    (bank_rd[m]),
            .wr    (bank_wr[m]),
            .addr  (bank_addr[m]),
            .wdata (bank_wdata[m]),
            .be    (bank_be[m]),
            .rdata (bank_rdata[m])
        );
    end

    // The SRAM read register is shared with host reads, so each consumer keeps its own hold copy.
    always_comb begin
        for (int m = 0; m < NUM_MEMS; m++) begin
            xlr_mem_rdata[m] = xlr_pend[m] ? bank_rdata[m] : xlr_hold[m];
        end
        host_rdata = host_hold;
        if (host_pend) begin
            host_rdata = '0;
            if (host_pend_ok) begin
                for (int m = 0; m < NUM_MEMS; m++) begin
                    if (host_sel_q == SEL_W'(m)) begin
                        host_rdata = bank_rdata[m][host_word_q];
                    end
                end
            end
        end
    end

    assign host_rvalid = host_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xlr_pend     <= '0;
            host_pend    <= 1'b0;
            host_pend_ok <= 1'b0;
            host_sel_q   <= '0;
            host_word_q  <= '0;
            host_hold    <= '0;
            conflict_cnt <= '0;
            for (int m = 0; m < NUM_MEMS; m++) begin
                xlr_hold[m] <= '0;
            end
        end else begin
            xlr_pend     <= xlr_mem_rd;
            host_pend    <= host_gnt & ~host_wr;
            host_pend_ok <= host_sel_ok;
            host_sel_q   <= host_sel;
            host_word_q  <= host_word;
            host_hold    <= host_rdata;
            for (int m = 0; m < NUM_MEMS; m++) begin
                xlr_hold[m] <= xlr_mem_rdata[m];
            end
            if (host_req && !host_gnt && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_xbox_xlr_mem_bank.sv
// Randomized bench for xbox_xlr_mem_bank: an array-based memory model predicts every
// output each cycle, and directed scenarios pin the model with literal expectations.
module tb_xbox_xlr_mem_bank;
    import xbox_mem_pkg::*;

    localparam int NUM = 2;
    localparam int AW  = 8;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b1;
    logic [NUM-1:0][AW-1:0]    xlr_mem_addr;
    line_t [NUM-1:0]           xlr_mem_wdata;
    be_t   [NUM-1:0]           xlr_mem_be;
    logic [NUM-1:0]            xlr_mem_rd;
    logic [NUM-1:0]            xlr_mem_wr;
    line_t [NUM-1:0]           xlr_mem_rdata;
    logic                      host_req;
    logic                      host_wr;
    logic [0:0]                host_sel;
    logic [AW-1:0]             host_addr;
    logic [2:0]                host_word;
    logic [31:0]               host_wdata;
    logic                      host_gnt;
    logic [31:0]               host_rdata;
    logic                      host_rvalid;
    logic [15:0]               conflict_cnt;

    xbox_xlr_mem_bank #(.NUM_MEMS(NUM), .LOG2_LINES_PER_MEM(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .xlr_mem_addr  (xlr_mem_addr),
        .xlr_mem_wdata (xlr_mem_wdata),
        .xlr_mem_be    (xlr_mem_be),
        .xlr_mem_rd    (xlr_mem_rd),
        .xlr_mem_wr    (xlr_mem_wr),
        .xlr_mem_rdata (xlr_mem_rdata),
        .host_req      (host_req),
        .host_wr       (host_wr),
        .host_sel      (host_sel),
        .host_addr     (host_addr),
        .host_word     (host_word),
        .host_wdata    (host_wdata),
        .host_gnt      (host_gnt),
        .host_rdata    (host_rdata),
        .host_rvalid   (host_rvalid),
        .conflict_cnt  (conflict_cnt)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;
    bit checking   = 1'b0;

    logic [255:0] mdl [NUM][256];
    logic [255:0] expX [NUM];
    logic [31:0]  expHr;
    logic         expHrv;
    logic [15:0]  expCnt;
    logic         hostStalled;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic expectGnt();
        logic busy = 1'b0;
        for (int m = 0; m < NUM; m++) begin
            if (int'(host_sel) == m) busy = xlr_mem_rd[m] | xlr_mem_wr[m];
        end
        return host_req & ~busy;
    endfunction

    // Reference model: memory as plain arrays, updated once per clock from the sampled inputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < NUM; m++) expX[m] = '0;
            expHr       = '0;
            expHrv      = 1'b0;
            expCnt      = '0;
            hostStalled = 1'b0;
        end else begin
            logic g;
            logic [255:0] line;
            g = expectGnt();
            hostStalled = host_req & ~g;
            if (hostStalled && expCnt != 16'hFFFF) expCnt = expCnt + 16'd1;
            for (int m = 0; m < NUM; m++) begin
                if (xlr_mem_rd[m]) expX[m] = mdl[m][xlr_mem_addr[m]];
            end
            expHrv = g & ~host_wr;
            if (expHrv) expHr = (int'(host_sel) < NUM) ? mdl[host_sel][host_addr][host_word*32 +: 32] : 32'h0;
            for (int m = 0; m < NUM; m++) begin
                if (xlr_mem_wr[m]) begin
                    line = xlr_mem_wdata[m];
                    for (int b = 0; b < 32; b++) begin
                        if (xlr_mem_be[m][b]) mdl[m][xlr_mem_addr[m]][b*8 +: 8] = line[b*8 +: 8];
                    end
                end
            end
            if (g && host_wr && int'(host_sel) < NUM) mdl[host_sel][host_addr][host_word*32 +: 32] = host_wdata;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int m = 0; m < NUM; m++) checkOutput($sformatf("xlr_rdata[%0d]", m), xlr_mem_rdata[m], expX[m]);
            checkOutput("host_rvalid", host_rvalid, expHrv);
            if (expHrv) checkOutput("host_rdata", host_rdata, expHr);
            checkOutput("conflict_cnt", conflict_cnt, expCnt);
            checkOutput("host_gnt", host_gnt, expectGnt());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        xlr_mem_addr  = '0;
        xlr_mem_wdata = '0;
        xlr_mem_be    = '0;
        xlr_mem_rd    = '0;
        xlr_mem_wr    = '0;
        host_req      = 1'b0;
        host_wr       = 1'b0;
        host_sel      = '0;
        host_addr     = '0;
        host_word     = '0;
        host_wdata    = '0;
    endtask

    task automatic applyStimulus();
        for (int m = 0; m < NUM; m++) begin
            xlr_mem_rd[m]   = ($urandom_range(0, 2) == 0);
            xlr_mem_wr[m]   = ($urandom_range(0, 2) == 0);
            xlr_mem_addr[m] = AW'($urandom_range(0, 7));
            for (int w = 0; w < 8; w++) xlr_mem_wdata[m][w] = $urandom;
            case ($urandom_range(0, 3))
                0:       xlr_mem_be[m] = '0;
                1:       xlr_mem_be[m] = '1;
                default: xlr_mem_be[m] = $urandom;
            endcase
        end
        if (!hostStalled) begin
            host_req   = 1'($urandom_range(0, 1));
            host_wr    = 1'($urandom_range(0, 1));
            host_sel   = 1'($urandom_range(0, NUM-1));
            host_addr  = AW'($urandom_range(0, 7));
            host_word  = 3'($urandom_range(0, 7));
            host_wdata = $urandom;
        end
    endtask

    initial begin
        line_t lit;
        idleInputs();
        #1 rst_n = 1'b0;
        #1 checking = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int a = 0; a < 8; a++) begin
            xlr_mem_wr = '1;
            xlr_mem_be = '1;
            xlr_mem_addr[0] = AW'(a);
            xlr_mem_addr[1] = AW'(a);
            step();
        end
        idleInputs();

        // Host stalls three cycles behind accelerator reads on bank0, then is granted.
        xlr_mem_rd[0] = 1'b1; xlr_mem_addr[0] = 8'd5;
        host_req = 1'b1; host_wr = 1'b0; host_sel = 1'b0; host_addr = 8'd3;
        for (int i = 0; i < 3; i++) begin
            #1 checkOutput("stall_gnt", host_gnt, 1'b0);
            step();
        end
        checkOutput("stall_cnt", conflict_cnt, 16'd3);
        xlr_mem_rd = '0;
        #1 checkOutput("late_gnt", host_gnt, 1'b1);
        step();
        checkOutput("late_rvalid", host_rvalid, 1'b1);
        checkOutput("late_rdata", host_rdata, 32'h0);
        xlr_mem_rd[0] = 1'b1; host_sel = 1'b1;
        #1 checkOutput("other_bank_gnt", host_gnt, 1'b1);
        step();
        idleInputs();

        for (int w = 0; w < 8; w++) begin
            host_req = 1'b1; host_wr = 1'b1; host_sel = 1'b0; host_addr = 8'd0;
            host_word = 3'(w); host_wdata = 32'(w + 1);
            step();
        end
        idleInputs();
        xlr_mem_rd[0] = 1'b1; xlr_mem_addr[0] = 8'd0;
        step();
        for (int w = 0; w < 8; w++) lit[w] = 32'(w + 1);
        checkOutput("host_fill_line0", xlr_mem_rdata[0], lit);

        idleInputs();
        xlr_mem_wr[0] = 1'b1; xlr_mem_addr[0] = 8'd1; xlr_mem_wdata[0] = '1; xlr_mem_be[0] = 32'h0000000F;
        step();
        idleInputs();
        xlr_mem_rd[0] = 1'b1; xlr_mem_addr[0] = 8'd1;
        step();
        lit = '0; lit[0] = 32'hFFFFFFFF;
        checkOutput("be_word0_only", xlr_mem_rdata[0], lit);

        idleInputs();
        xlr_mem_wr[0] = 1'b1; xlr_mem_addr[0] = 8'd2; xlr_mem_be[0] = '1;
        xlr_mem_wdata[0] = word_splat(32'hA5A5A5A5);
        step();
        xlr_mem_rd[0] = 1'b1; xlr_mem_wdata[0] = '0;
        step();
        checkOutput("rbw_old_line", xlr_mem_rdata[0], word_splat(32'hA5A5A5A5));
        xlr_mem_wr = '0;
        step();
        checkOutput("rbw_new_line", xlr_mem_rdata[0], 256'h0);

        idleInputs();
        xlr_mem_rd[0] = 1'b1;
        for (int a = 0; a < 3; a++) begin
            xlr_mem_addr[0] = AW'(a);
            step();
            lit = '0;
            if (a == 0) for (int w = 0; w < 8; w++) lit[w] = 32'(w + 1);
            if (a == 1) lit[0] = 32'hFFFFFFFF;
            checkOutput($sformatf("b2b_line%0d", a), xlr_mem_rdata[0], lit);
        end

        idleInputs();
        host_req = 1'b1; host_sel = 1'b0; host_addr = 8'd0; host_word = 3'd4;
        step();
        idleInputs();
        checkOutput("pre_reset_rvalid", host_rvalid, 1'b1);
        checkOutput("pre_reset_rdata", host_rdata, 32'd5);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_rvalid", host_rvalid, 1'b0);
        checkOutput("reset_rdata", host_rdata, 32'h0);
        checkOutput("reset_xlr_rdata", xlr_mem_rdata[0], 256'h0);
        checkOutput("reset_cnt", conflict_cnt, 16'h0);
        step();
        rst_n = 1'b1;
        xlr_mem_rd[0] = 1'b1; xlr_mem_addr[0] = 8'd0;
        step();
        for (int w = 0; w < 8; w++) lit[w] = 32'(w + 1);
        checkOutput("post_reset_line0", xlr_mem_rdata[0], lit);

        idleInputs();
        repeat (3000) begin
            applyStimulus();
            step();
        end
        idleInputs();
        step();
        checking = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
